// File: rtl/fifo_pkg.sv
// fifo_pkg: shared FIFO constants and Gray/binary conversion helpers for both pointer domains.
package fifo_pkg;
  localparam int ADDR_SIZE_DEF = 4;
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
endpackage

// File: rtl/gray2bin_conv.sv
// gray2bin_conv: purely combinational Gray-to-binary decoder of parameterized width.
module gray2bin_conv
  import fifo_pkg::*;
#(
  parameter int W = 5
) (
  input  logic [W-1:0] gray_i,
  output logic [W-1:0] bin_o
);
  assign bin_o = W'(gray2bin(32'(gray_i)));
endmodule

// File: rtl/wptr_full_ctrl.sv
// wptr_full_ctrl: write-side pointer, full/almost-full, level and sticky overflow for an async FIFO.
module wptr_full_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_SIZE    = ADDR_SIZE_DEF,
  parameter int AFULL_THRESH = 12
) (
  input  logic                 WCLK,
  input  logic                 WRST,
  input  logic                 WINC,
  input  logic [ADDR_SIZE:0]   WQ2_RPTR,
  input  logic                 WOVF_CLR,
  output logic                 WEN,
  output logic [ADDR_SIZE-1:0] WADDR,
  output logic [ADDR_SIZE:0]   WPTR,
  output logic                 WFULL,
  output logic                 WAFULL,
  output logic [ADDR_SIZE:0]   WLEVEL,
  output logic                 WOVF
);
  localparam int PW = ADDR_SIZE + 1;
  logic [ADDR_SIZE:0] wbin_q, wbin_d, wptr_q, wptr_d, wlevel_q, wlevel_d, rbin, rfull;
  logic               wfull_q, wfull_d, wafull_q, wafull_d, wovf_q, wovf_d;
  gray2bin_conv #(.W(PW)) u_rconv (.gray_i(WQ2_RPTR), .bin_o(rbin));
  assign WEN    = WINC & ~wfull_q & ~WRST;
  assign WADDR  = wbin_q[ADDR_SIZE-1:0];
  assign WPTR   = wptr_q;
  assign WFULL  = wfull_q;
  assign WAFULL = wafull_q;
  assign WLEVEL = wlevel_q;
  assign WOVF   = wovf_q;
  // full when our next Gray pointer equals the read pointer one lap ahead
  assign rfull  = {~WQ2_RPTR[ADDR_SIZE:ADDR_SIZE-1], WQ2_RPTR[ADDR_SIZE-2:0]};
  always_comb begin
    wbin_d   = wbin_q + PW'(WEN);
    wptr_d   = PW'(bin2gray(32'(wbin_d)));
    wfull_d  = wptr_d == rfull;
    wlevel_d = wbin_d - rbin;
    wafull_d = wfull_d | (wlevel_d >= PW'(AFULL_THRESH));
    wovf_d   = (WINC & wfull_q) ? 1'b1 : (WOVF_CLR ? 1'b0 : wovf_q);
  end
  always_ff @(posedge WCLK) begin
    if (WRST) begin
      wbin_q   <= '0;
      wptr_q   <= '0;
      wlevel_q <= '0;
      wfull_q  <= 1'b0;
      wafull_q <= 1'b0;
      wovf_q   <= 1'b0;
    end else begin
      wbin_q   <= wbin_d;
      wptr_q   <= wptr_d;
      wlevel_q <= wlevel_d;
      wfull_q  <= wfull_d;
      wafull_q <= wafull_d;
      wovf_q   <= wovf_d;
    end
  end
endmodule

// File: tb/tb_wptr_full_ctrl.sv
// tb_wptr_full_ctrl: table vectors plus model-driven scoreboard for the FIFO write-side controller.
module tb_wptr_full_ctrl;
  logic       WCLK = 1'b0, WRST = 1'b1, WINC = 1'b0, WOVF_CLR = 1'b0;
  logic [4:0] WQ2_RPTR = '0;
  logic       WEN, WFULL, WAFULL, WOVF, wen16, wfull16, wafull16, wovf16;
  logic [3:0] WADDR, waddr16;
  logic [4:0] WPTR, WLEVEL, wptr16, wlevel16;
  int checks = 0, errors = 0;
  always #5 WCLK = ~WCLK;
  wptr_full_ctrl #(.ADDR_SIZE(4), .AFULL_THRESH(12)) dut (
    .WCLK(WCLK), .WRST(WRST), .WINC(WINC), .WQ2_RPTR(WQ2_RPTR), .WOVF_CLR(WOVF_CLR),
    .WEN(WEN), .WADDR(WADDR), .WPTR(WPTR), .WFULL(WFULL), .WAFULL(WAFULL),
    .WLEVEL(WLEVEL), .WOVF(WOVF));
  wptr_full_ctrl #(.ADDR_SIZE(4), .AFULL_THRESH(16)) dut16 (
    .WCLK(WCLK), .WRST(WRST), .WINC(WINC), .WQ2_RPTR(WQ2_RPTR), .WOVF_CLR(WOVF_CLR),
    .WEN(wen16), .WADDR(waddr16), .WPTR(wptr16), .WFULL(wfull16), .WAFULL(wafull16),
    .WLEVEL(wlevel16), .WOVF(wovf16));
  typedef struct {
    logic [4:0] ptr, lvl;
    logic       full, afull, ovf;
  } exp_t;
  typedef struct {
    logic       winc;
    logic [4:0] rb;
    logic       clr;
    logic [3:0] waddr;
    logic [4:0] wptr, lvl;
    logic       afull, full, ovf;
  } vec_t;
  exp_t sb[$];
  vec_t vec[24];
  logic [4:0] m_bin = '0, m_lvl = '0, rb = '0;
  logic       m_full = 1'b0, m_afull = 1'b0, m_ovf = 1'b0;
  int         lvl_i;
  function automatic logic [4:0] to_gray(input logic [4:0] b);
    logic [4:0] g;
    for (int i = 0; i < 4; i++) g[i] = b[i] ^ b[i+1];
    g[4] = b[4];
    return g;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // one clock: drive inputs, check write strobe/address, predict and check registered outputs
  task automatic cycle(input logic winc, input logic [4:0] rbin, input logic clr);
    exp_t e;
    logic exp_wen;
    WINC = winc;
    WQ2_RPTR = to_gray(rbin);
    WOVF_CLR = clr;
    #1;
    exp_wen = winc && !m_full && !WRST;
    chk("wen", WEN, exp_wen);
    chk("waddr", WADDR, m_bin[3:0]);
    if (WRST) begin
      m_bin = '0; m_lvl = '0; m_full = 0; m_afull = 0; m_ovf = 0;
    end else begin
      m_ovf = (winc && m_full) || (m_ovf && !clr);
      if (exp_wen) m_bin = m_bin + 5'd1;
      lvl_i = (int'(m_bin) - int'(rbin) + 32) % 32;
      m_lvl = 5'(lvl_i);
      m_full = lvl_i == 16;
      m_afull = lvl_i >= 12;
    end
    e.ptr = to_gray(m_bin); e.lvl = m_lvl; e.full = m_full; e.afull = m_afull; e.ovf = m_ovf;
    sb.push_back(e);
    @(posedge WCLK);
    #1;
    e = sb.pop_front();
    chk("wptr", WPTR, e.ptr);
    chk("wlevel", WLEVEL, e.lvl);
    chk("wfull", WFULL, e.full);
    chk("wafull", WAFULL, e.afull);
    chk("wovf", WOVF, e.ovf);
    chk("wafull_t16", wafull16, e.full);
    chk("wfull_t16", wfull16, e.full);
  endtask
  initial begin
    logic [4:0] g [16];
    g = '{5'b00001, 5'b00011, 5'b00010, 5'b00110, 5'b00111, 5'b00101, 5'b00100, 5'b01100,
          5'b01101, 5'b01111, 5'b01110, 5'b01010, 5'b01011, 5'b01001, 5'b01000, 5'b11000};
    for (int i = 0; i < 16; i++)
      vec[i] = '{1'b1, 5'd0, 1'b0, 4'(i), g[i], 5'(i + 1), i >= 11, i == 15, 1'b0};
    vec[16] = '{1'b1, 5'd0, 1'b0, 4'd0, 5'b11000, 5'd16, 1'b1, 1'b1, 1'b1};
    vec[17] = '{1'b1, 5'd0, 1'b0, 4'd0, 5'b11000, 5'd16, 1'b1, 1'b1, 1'b1};
    vec[18] = '{1'b1, 5'd0, 1'b0, 4'd0, 5'b11000, 5'd16, 1'b1, 1'b1, 1'b1};
    vec[19] = '{1'b0, 5'd0, 1'b1, 4'd0, 5'b11000, 5'd16, 1'b1, 1'b1, 1'b0};
    vec[20] = '{1'b1, 5'd0, 1'b1, 4'd0, 5'b11000, 5'd16, 1'b1, 1'b1, 1'b1};
    vec[21] = '{1'b0, 5'd0, 1'b1, 4'd0, 5'b11000, 5'd16, 1'b1, 1'b1, 1'b0};
    vec[22] = '{1'b0, 5'd1, 1'b0, 4'd0, 5'b11000, 5'd15, 1'b1, 1'b0, 1'b0};
    vec[23] = '{1'b1, 5'd1, 1'b0, 4'd0, 5'b11001, 5'd16, 1'b1, 1'b1, 1'b0};
    WINC = 1'b1;
    @(posedge WCLK);
    #1;
    cycle(1'b1, 5'd0, 1'b0);
    cycle(1'b1, 5'd0, 1'b0);
    chk("rst_wen", WEN, 1'b0);
    WRST = 1'b0;
    for (int i = 0; i < 24; i++) begin
      #1;
      chk($sformatf("vec%0d_waddr", i), WADDR, vec[i].waddr);
      cycle(vec[i].winc, vec[i].rb, vec[i].clr);
      chk($sformatf("vec%0d_wptr", i), WPTR, vec[i].wptr);
      chk($sformatf("vec%0d_lvl", i), WLEVEL, vec[i].lvl);
      chk($sformatf("vec%0d_afull", i), WAFULL, vec[i].afull);
      chk($sformatf("vec%0d_full", i), WFULL, vec[i].full);
      chk($sformatf("vec%0d_ovf", i), WOVF, vec[i].ovf);
    end
    WRST = 1'b1;
    cycle(1'b0, 5'd0, 1'b0);
    WRST = 1'b0;
    rb = '0;
    for (int i = 0; i < 40; i++) begin
      cycle(1'b1, rb, 1'b0);
      rb = rb + 5'd1;
      cycle(1'b0, rb, 1'b0);
    end
    chk("wrap_waddr", WADDR, 4'd8);
    chk("wrap_wptr", WPTR, to_gray(5'd8));
    for (int i = 0; i < 300; i++) begin
      if (($urandom % 3) == 0 && rb != m_bin) rb = rb + 5'd1;
      cycle(1'($urandom % 4 != 0), rb, 1'($urandom % 8 == 0));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
